// File: rtl/jtcontra_scan2x_pkg.sv
// Shared defaults, sync bundle type and the 5:5:5 colour packing helper for the
// Contra line-doubling scan converter.
package jtcontra_scan2x_pkg;

    localparam int HW_DEF     = 9;
    localparam int DW_DEF     = 15;
    localparam int HS_OFS_DEF = 16;
    localparam int HS_LEN_DEF = 32;

    // Timing flags that travel through the output pipeline alongside the pixel
    typedef struct packed {
        logic lhbl;
        logic hs;
        logic lvbl;
        logic vs;
    } sync_t;

    function automatic logic [14:0] pack_rgb(
        input logic [4:0] r,
        input logic [4:0] g,
        input logic [4:0] b
    );
        return {r, g, b};
    endfunction

endpackage

// File: rtl/jtcontra_scan2x_lbuf.sv
// Simple dual-port line buffer holding both ping-pong halves; registered read
// so it maps onto block RAM.
module jtcontra_scan2x_lbuf #(
    parameter int AW = 10,
    parameter int DW = 15
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/jtcontra_scan2x.sv
// Line doubler: stores each input line in one half of a ping-pong buffer and
// replays the previously completed line twice at the 2x pixel rate.
module jtcontra_scan2x
    import jtcontra_scan2x_pkg::*;
#(
    parameter int HW     = HW_DEF,
    parameter int DW     = DW_DEF,
    parameter int HS_OFS = HS_OFS_DEF,
    parameter int HS_LEN = HS_LEN_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pxl_cen,
    input  logic       pxl2_cen,
    input  logic [4:0] red,
    input  logic [4:0] green,
    input  logic [4:0] blue,
    input  logic       LHBL,
    input  logic       LVBL,
    input  logic       VS,
    output logic [4:0] red2x,
    output logic [4:0] green2x,
    output logic [4:0] blue2x,
    output logic       LHBL2x,
    output logic       LVBL2x,
    output logic       HS2x,
    output logic       VS2x
);

    localparam int EW = HW + 2;
    localparam logic [HW-1:0] CNT_MAX = '1;

    logic          lhbl_reg;
    logic [HW-1:0] wr_addr_reg;
    logic [HW-1:0] tot_cnt_reg;
    logic [HW-1:0] act_len_reg;
    logic [HW-1:0] tot_len_reg;
    logic [HW-1:0] rd_cnt_reg;
    logic          wsel_reg;
    logic          lvbl_l_reg;
    logic          vs_l_reg;
    logic          seen_reg;
    logic          valid_reg;
    logic          line_end;
    logic          wr_en;
    logic          rd_wrap;
    logic [HW-1:0] tot_len_next;
    logic [EW-1:0] hs_start;
    logic [EW-1:0] hs_stop;
    logic [EW-1:0] rd_ext;
    logic [DW-1:0] rgb_in;
    logic [DW-1:0] rd_data;
    logic [DW-1:0] rgb_out;
    sync_t         sync_next;
    sync_t         sync_reg;

    assign rgb_in   = pack_rgb(red, green, blue);
    assign line_end = pxl_cen && lhbl_reg && !LHBL;
    assign wr_en    = pxl_cen && LHBL && (wr_addr_reg != CNT_MAX) && !rst;

    assign tot_len_next = (tot_cnt_reg == CNT_MAX) ? CNT_MAX : tot_cnt_reg + 1'b1;

    // Write side: capture the line, measure it, and flip buffers on LHBL fall
    always_ff @(posedge clk) begin
        if (rst) begin
            lhbl_reg    <= 1'b0;
            wr_addr_reg <= '0;
            tot_cnt_reg <= '0;
            act_len_reg <= '0;
            tot_len_reg <= '0;
            wsel_reg    <= 1'b0;
            lvbl_l_reg  <= 1'b0;
            vs_l_reg    <= 1'b0;
            seen_reg    <= 1'b0;
            valid_reg   <= 1'b0;
        end else if (pxl_cen) begin
            lhbl_reg <= LHBL;
            if (line_end) begin
                act_len_reg <= wr_addr_reg;
                tot_len_reg <= tot_len_next;
                wr_addr_reg <= '0;
                tot_cnt_reg <= '0;
                wsel_reg    <= ~wsel_reg;
                lvbl_l_reg  <= LVBL;
                vs_l_reg    <= VS;
                seen_reg    <= 1'b1;
                // The first completed line after reset may be partial
                valid_reg   <= valid_reg | seen_reg;
            end else begin
                if (wr_en) begin
                    wr_addr_reg <= wr_addr_reg + 1'b1;
                end
                if (tot_cnt_reg != CNT_MAX) begin
                    tot_cnt_reg <= tot_cnt_reg + 1'b1;
                end
            end
        end
    end

    assign rd_wrap = (tot_len_reg < HW'(2)) || (rd_cnt_reg == tot_len_reg - 1'b1);

    // Read side: line_end restarts the replay even if it lands on a wrap tick
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_reg <= '0;
        end else if (line_end) begin
            rd_cnt_reg <= '0;
        end else if (pxl2_cen) begin
            rd_cnt_reg <= rd_wrap ? '0 : rd_cnt_reg + 1'b1;
        end
    end

    jtcontra_scan2x_lbuf #(
        .AW (HW + 1),
        .DW (DW)
    ) u_lbuf (
        .clk     (clk),
        .we      (wr_en),
        .wr_addr ({wsel_reg, wr_addr_reg}),
        .wr_data (rgb_in),
        .rd_en   (pxl2_cen),
        .rd_addr ({~wsel_reg, rd_cnt_reg}),
        .rd_data (rd_data)
    );

    assign rd_ext   = EW'(rd_cnt_reg);
    assign hs_start = EW'(act_len_reg) + EW'(HS_OFS);
    assign hs_stop  = hs_start + EW'(HS_LEN);

    always_comb begin
        sync_next      = '0;
        sync_next.lhbl = valid_reg && (rd_cnt_reg < act_len_reg);
        sync_next.hs   = valid_reg && (rd_ext >= hs_start) && (rd_ext < hs_stop);
        sync_next.lvbl = valid_reg && lvbl_l_reg;
        sync_next.vs   = valid_reg && vs_l_reg;
    end

    // Timing flags take the same one-tick delay as the RAM read
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_reg <= '0;
        end else if (pxl2_cen) begin
            sync_reg <= sync_next;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DW; gi++) begin : g_mask
            assign rgb_out[gi] = rd_data[gi] & sync_reg.lhbl;
        end
    endgenerate

    assign red2x   = rgb_out[14:10];
    assign green2x = rgb_out[9:5];
    assign blue2x  = rgb_out[4:0];
    assign LHBL2x  = sync_reg.lhbl;
    assign LVBL2x  = sync_reg.lvbl;
    assign HS2x    = sync_reg.hs;
    assign VS2x    = sync_reg.vs;

endmodule

// File: tb/tb_jtcontra_scan2x.sv
// Scoreboard bench for the line doubler: each driven pixel queues the two
// expected 2x-rate output samples, and a monitor pops one per pxl2_cen tick.
module tb_jtcontra_scan2x;

    logic       clk;
    logic       rst;
    logic       pxl_cen;
    logic       pxl2_cen;
    logic [4:0] red;
    logic [4:0] green;
    logic [4:0] blue;
    logic       LHBL;
    logic       LVBL;
    logic       VS;
    logic [4:0] red2x;
    logic [4:0] green2x;
    logic [4:0] blue2x;
    logic       LHBL2x;
    logic       LVBL2x;
    logic       HS2x;
    logic       VS2x;

    jtcontra_scan2x dut (
        .clk      (clk),
        .rst      (rst),
        .pxl_cen  (pxl_cen),
        .pxl2_cen (pxl2_cen),
        .red      (red),
        .green    (green),
        .blue     (blue),
        .LHBL     (LHBL),
        .LVBL     (LVBL),
        .VS       (VS),
        .red2x    (red2x),
        .green2x  (green2x),
        .blue2x   (blue2x),
        .LHBL2x   (LHBL2x),
        .LVBL2x   (LVBL2x),
        .HS2x     (HS2x),
        .VS2x     (VS2x)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected sample layout: {rgb[14:0], lhbl, lvbl, hs, vs}
    logic [18:0] expq[$];
    int          total;
    int          bad;
    int          tick;

    // Reference state: current line being captured and the last completed line
    int          wcnt;
    int          tcnt;
    int          ends;
    int          slot;
    int          d_act;
    int          d_tot;
    bit          d_lvbl;
    bit          d_vs;
    bit          d_valid;
    bit          lhbl_prev;
    logic [14:0] cur_pix [512];
    logic [14:0] d_pix   [512];

    function automatic logic [18:0] expect_at(input int j);
        logic [18:0] e;
        int          pos;
        bit          act;
        e = '0;
        if (!d_valid) return e;
        pos = (d_tot < 2) ? 0 : (j - 1) % d_tot;
        act = (pos < d_act);
        e[18:4] = act ? d_pix[pos] : 15'd0;
        e[3]    = act;
        e[2]    = d_lvbl;
        e[1]    = (pos >= d_act + 16) && (pos < d_act + 48);
        e[0]    = d_vs;
        return e;
    endfunction

    task automatic model_reset();
        wcnt      = 0;
        tcnt      = 0;
        ends      = 0;
        slot      = 0;
        d_act     = 0;
        d_tot     = 0;
        d_lvbl    = 0;
        d_vs      = 0;
        d_valid   = 0;
        lhbl_prev = 0;
    endtask

    // One input pixel = 4 clk: pxl_cen+pxl2_cen, idle, pxl2_cen, idle.
    // rmode 1 pulses rst for the first clk only, rmode 2 holds it all pixel.
    task automatic drive_px(input logic [14:0] rgb, input bit hb, input bit vb,
                            input bit v, input int rmode);
        bit le;
        red      = rgb[14:10];
        green    = rgb[9:5];
        blue     = rgb[4:0];
        LHBL     = hb;
        LVBL     = vb;
        VS       = v;
        pxl_cen  = 1'b1;
        pxl2_cen = 1'b1;
        rst      = (rmode != 0);
        if (rmode != 0) begin
            model_reset();
            expq.push_back('0);
            expq.push_back('0);
        end else begin
            le = lhbl_prev && !hb;
            slot++;
            expq.push_back(expect_at(slot));
            if (le) begin
                d_act   = wcnt;
                d_tot   = (tcnt + 1 > 511) ? 511 : tcnt + 1;
                d_lvbl  = vb;
                d_vs    = v;
                d_pix   = cur_pix;
                ends++;
                d_valid = (ends >= 2);
                wcnt    = 0;
                tcnt    = 0;
                slot    = 0;
            end else begin
                if (hb && wcnt < 511) begin
                    cur_pix[wcnt] = rgb;
                    wcnt++;
                end
                if (tcnt < 511) tcnt++;
            end
            lhbl_prev = hb;
            slot++;
            expq.push_back(expect_at(slot));
        end
        @(negedge clk);
        pxl_cen  = 1'b0;
        pxl2_cen = 1'b0;
        rst      = (rmode == 2);
        @(negedge clk);
        pxl2_cen = 1'b1;
        @(negedge clk);
        pxl2_cen = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_line(input int tot, input int act, input int base,
                            input bit v, input bit vb, input int rst_at);
        $display("line: tot=%0d act=%0d base=%0d vs=%0d lvbl=%0d rst_at=%0d",
                 tot, act, base, v, vb, rst_at);
        for (int n = 0; n < tot; n++) begin
            bit          hb;
            logic [14:0] px;
            hb = (n < act);
            px = hb ? 15'(base + n) : 15'h7fff;
            drive_px(px, hb, vb, v, (n == rst_at) ? 1 : 0);
        end
    endtask

    // Monitor: one popped sample per pxl2_cen tick, sampled 1 ns after the edge
    initial begin
        logic [18:0] got;
        logic [18:0] exp_v;
        tick = 0;
        forever begin
            @(posedge clk);
            if (pxl2_cen) begin
                #1;
                tick++;
                got = {red2x, green2x, blue2x, LHBL2x, LVBL2x, HS2x, VS2x};
                total++;
                if (expq.size() == 0) begin
                    bad++;
                    $display("FAIL underrun tick=%0d got=%h required=<queued sample>", tick, got);
                end else begin
                    exp_v = expq.pop_front();
                    if (got !== exp_v) begin
                        bad++;
                        $display("FAIL video tick=%0d got rgb=%h lhbl=%b lvbl=%b hs=%b vs=%b required rgb=%h lhbl=%b lvbl=%b hs=%b vs=%b",
                                 tick, got[18:4], got[3], got[2], got[1], got[0],
                                 exp_v[18:4], exp_v[3], exp_v[2], exp_v[1], exp_v[0]);
                    end
                end
            end
        end
    end

    initial begin
        total    = 0;
        bad      = 0;
        rst      = 1'b1;
        pxl_cen  = 1'b0;
        pxl2_cen = 1'b0;
        red      = '0;
        green    = '0;
        blue     = '0;
        LHBL     = 1'b0;
        LVBL     = 1'b0;
        VS       = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (3) drive_px(15'd0, 1'b0, 1'b0, 1'b0, 2);

        run_line(384, 256,     0, 1'b0, 1'b1, -1);
        run_line(384, 256,     0, 1'b0, 1'b1, -1);
        run_line(384, 256,  1000, 1'b0, 1'b1, -1);
        run_line(384, 256,  2000, 1'b1, 1'b1, -1);
        run_line(384, 256,  3000, 1'b0, 1'b0, -1);
        run_line(300, 256,  4000, 1'b0, 1'b1, -1);
        run_line(300, 256,  5000, 1'b0, 1'b1, -1);
        run_line(384,   0,     0, 1'b0, 1'b1, -1);
        run_line(700, 600,     0, 1'b0, 1'b1, -1);
        run_line(384, 256,  6000, 1'b0, 1'b1, -1);
        run_line(384, 256,  7000, 1'b0, 1'b1, 100);
        run_line(384, 256,  8000, 1'b0, 1'b1, -1);
        run_line(384, 256,  9000, 1'b0, 1'b1, -1);
        run_line(384, 256, 10000, 1'b0, 1'b1, -1);

        rst = 1'b0;
        repeat (4) @(negedge clk);
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain left=%0d required=0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
